// File: rtl/register_file_32x32_pkg.sv
// register_file_32x32_pkg: datapath-wide width and register-count constants
package register_file_32x32_pkg;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_NUM_REGS = 32;
endpackage

// File: rtl/decoder_5x32.sv
// decoder_5x32: one-hot line decoder with a global enable
module decoder_5x32 #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]    sel,
  input  logic                     en,
  output logic [2**ADDR_WIDTH-1:0] lines
);
  // drive exactly one line high when enabled, none otherwise
  always_comb lines = en ? (2**ADDR_WIDTH)'(1) << sel : '0;
endmodule

// File: rtl/mux_32x1.sv
// mux_32x1: 32-input word-wide selector for one read port
module mux_32x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] din [2**ADDR_WIDTH],
  input  logic [ADDR_WIDTH-1:0] sel,
  output logic [DATA_WIDTH-1:0] dout
);
  // pick the addressed word
  always_comb dout = din[sel];
endmodule

// File: rtl/register_file_32x32.sv
// register_file_32x32: 2-read/1-write register file, r0 hardwired to zero, registered reads with write-through
module register_file_32x32
  import register_file_32x32_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2,
  output logic                  RD_VALID
);
  localparam int NR = 2**ADDR_WIDTH;
  logic [NR-1:0] dec;
  logic [NR-1:0] we;
  logic [DATA_WIDTH-1:0] regs [NR];
  logic [DATA_WIDTH-1:0] m1, m2, b1, b2;
  logic byp1, byp2;
  decoder_5x32 #(.ADDR_WIDTH(ADDR_WIDTH)) u_dec (
    .sel(ADDR_W),
    .en(WRITE),
    .lines(dec)
  );
  assign we = dec & {{(NR-1){1'b1}}, 1'b0};
  assign regs[0] = '0;
  for (genvar i = 1; i < NR; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;
    // each register loads the write data when its decoded enable fires
    always_ff @(posedge CLK) q <= RESET ? '0 : we[i] ? DATA_W : q;
    assign regs[i] = q;
  end
  mux_32x1 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux1 (
    .din(regs),
    .sel(ADDR_R1),
    .dout(m1)
  );
  mux_32x1 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux2 (
    .din(regs),
    .sel(ADDR_R2),
    .dout(m2)
  );
  // same-edge write to a read address returns the incoming data; r0 never bypasses
  always_comb begin
    byp1 = WRITE && ADDR_W != '0 && ADDR_R1 == ADDR_W;
    byp2 = WRITE && ADDR_W != '0 && ADDR_R2 == ADDR_W;
    b1 = byp1 ? DATA_W : m1;
    b2 = byp2 ? DATA_W : m2;
  end
  // read outputs load only on READ and hold otherwise; RD_VALID follows READ by one cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_R1 <= '0;
      DATA_R2 <= '0;
      RD_VALID <= 1'b0;
    end else begin
      RD_VALID <= READ;
      if (READ) begin
        DATA_R1 <= b1;
        DATA_R2 <= b2;
      end
    end
  end
endmodule

// File: tb/tb_register_file_32x32.sv
// tb_register_file_32x32: directed table, sweep and random checks against a behavioural model
module tb_register_file_32x32;
  logic clk = 1'b0;
  logic rst, rd, wr;
  logic [4:0] a1, a2, aw;
  logic [31:0] dw;
  logic [31:0] d1, d2;
  logic v;
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [32];
  logic [31:0] e1 = '0, e2 = '0;
  logic ev = 1'b0;
  typedef struct {
    logic rst, rd, wr;
    logic [4:0] a1, a2, aw;
    logic [31:0] dw, x1, x2;
    logic xv;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  register_file_32x32 dut (
    .CLK(clk), .RESET(rst), .READ(rd), .WRITE(wr),
    .ADDR_R1(a1), .ADDR_R2(a2), .ADDR_W(aw), .DATA_W(dw),
    .DATA_R1(d1), .DATA_R2(d2), .RD_VALID(v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic re, input logic we, input logic [4:0] x1,
                      input logic [4:0] x2, input logic [4:0] xw, input logic [31:0] xd);
    @(negedge clk);
    rst = r; rd = re; wr = we; a1 = x1; a2 = x2; aw = xw; dw = xd;
    @(posedge clk);
    if (r) begin
      foreach (mem[k]) mem[k] = '0;
      e1 = '0; e2 = '0; ev = 1'b0;
    end else begin
      ev = re;
      if (re) begin
        e1 = (we && xw != 0 && x1 == xw) ? xd : mem[x1];
        e2 = (we && xw != 0 && x2 == xw) ? xd : mem[x2];
      end
      if (we && xw != 0) mem[xw] = xd;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".r1"}, d1, e1);
    chk({tag, ".r2"}, d2, e2);
    chk({tag, ".valid"}, {31'b0, v}, {31'b0, ev});
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; a1 = '0; a2 = '0; aw = '0; dw = '0;
    foreach (mem[k]) mem[k] = '0;
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 5, 31, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 1, 0, 0, 3, 32'hDEAD_BEEF, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 3, 0, 0, 0, 32'hDEAD_BEEF, 0, 1};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 3, 0, 0, 0, 32'hDEAD_BEEF, 1};
    tbl[6]  = '{0, 1, 1, 7, 7, 7, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1};
    tbl[7]  = '{0, 0, 1, 1, 2, 9, 32'hA5A5_A5A5, 32'h1234_5678, 32'h1234_5678, 0};
    tbl[8]  = '{0, 1, 0, 9, 9, 0, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1};
    tbl[9]  = '{0, 0, 1, 3, 4, 9, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0};
    tbl[10] = '{0, 1, 1, 0, 3, 0, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF, 1};
    tbl[11] = '{0, 0, 0, 7, 3, 7, 32'h5555_5555, 0, 32'hDEAD_BEEF, 0};
    tbl[12] = '{0, 1, 0, 7, 9, 0, 0, 32'h1234_5678, 0, 1};
    tbl[13] = '{1, 1, 1, 7, 3, 3, 32'h7777_7777, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 3, 7, 0, 0, 0, 0, 1};
    tbl[15] = '{0, 1, 0, 0, 31, 0, 0, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].a1, tbl[i].a2, tbl[i].aw, tbl[i].dw);
      chk($sformatf("vec%0d.r1", i), d1, tbl[i].x1);
      chk($sformatf("vec%0d.r2", i), d2, tbl[i].x2);
      chk($sformatf("vec%0d.valid", i), {31'b0, v}, {31'b0, tbl[i].xv});
    end
    step(0, 1, 0, 1, 2, 0, 0);
    step(1, 1, 0, 1, 2, 0, 0);
    chk_model("midreset");
    step(0, 0, 0, 0, 0, 0, 0);
    chk_model("resume_idle");
    for (int i = 1; i < 32; i++) step(0, 0, 1, 0, 0, 5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 5'(i), 5'(31 - i), 0, 0);
      chk($sformatf("sweep%0d.r1", i), d1, 32'(i) * 32'h0101_0101);
      chk($sformatf("sweep%0d.r2", i), d2, 32'(31 - i) * 32'h0101_0101);
      chk($sformatf("sweep%0d.valid", i), {31'b0, v}, 32'd1);
    end
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), $urandom);
      chk_model($sformatf("rand%0d", i));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
